// File: rtl/noc_div_pkg.sv
// Shared types and helpers for the NoC serial divider: FSM state encoding,
// counter sizing and the power-of-two divisor helpers.
package noc_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEF_ADDR_WIDTH = 20;
    localparam int CNT_W          = $clog2(DEF_ADDR_WIDTH) + 1;

    // Counter width for an arbitrary dividend width; the step counter must reach ADDR_WIDTH-1.
    function automatic int cnt_width(input int addr_width);
        return $clog2(addr_width) + 1;
    endfunction

    function automatic logic is_pow2(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic logic [4:0] log2_onehot(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/noc_serial_divider_step.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module noc_div_step #(
    parameter int DIV_WIDTH = 4
) (
    input  logic [DIV_WIDTH-1:0] r_i,
    input  logic                 dvd_bit_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic [DIV_WIDTH-1:0] r_next_o,
    output logic                 q_bit_o
);

    logic [DIV_WIDTH:0] r_shift;
    logic [DIV_WIDTH:0] r_sub;

    assign r_shift = {r_i, dvd_bit_i};
    assign r_sub   = r_shift - {1'b0, div_i};
    assign q_bit_o = (r_shift >= {1'b0, div_i});

    // The restored remainder is always below the divisor, so it fits in DIV_WIDTH bits.
    assign r_next_o = q_bit_o ? r_sub[DIV_WIDTH-1:0] : r_shift[DIV_WIDTH-1:0];

endmodule

// File: rtl/noc_serial_divider.sv
// Multi-cycle unsigned restoring divider with valid/ready on both sides.
// Optional NOC_DIV_POW2_BYPASS_EN: one-hot divisors finish on the accept edge.
module noc_serial_divider
    import noc_div_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DIV_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_in,
    output logic                  rdy_in,
    input  logic [ADDR_WIDTH-1:0] data_in,
    input  logic [DIV_WIDTH-1:0]  div_in,
    output logic [ADDR_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0]  remainder,
    output logic                  div_zero,
    output logic                  vld_out,
    input  logic                  rdy_out
);

    localparam int                    CW       = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0]         LAST_CNT = CW'(ADDR_WIDTH - 1);

    div_state_t              state_q;
    logic [CW-1:0]           cnt_q;
    logic [ADDR_WIDTH-1:0]   dvd_q;
    logic [DIV_WIDTH-1:0]    dvs_q;
    logic [DIV_WIDTH-1:0]    r_q;
    logic [ADDR_WIDTH-1:0]   quotient_q;
    logic [DIV_WIDTH-1:0]    remainder_q;
    logic                    div_zero_q;
    logic                    vld_out_q;

    logic [DIV_WIDTH-1:0]    r_d;
    logic                    q_bit_d;
    logic                    accept;

    assign rdy_in = (state_q == IDLE) || ((state_q == DONE) && rdy_out);
    assign accept = vld_in && rdy_in;

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign vld_out   = vld_out_q;

    noc_div_step #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_step (
        .r_i       (r_q),
        .dvd_bit_i (dvd_q[ADDR_WIDTH-1]),
        .div_i     (dvs_q),
        .r_next_o  (r_d),
        .q_bit_o   (q_bit_d)
    );

    // The dividend register doubles as the quotient accumulator: each step
    // shifts the consumed dividend bit out the top and the new quotient bit in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            vld_out_q   <= 1'b0;
        end else if (accept) begin
            dvd_q <= data_in;
            dvs_q <= div_in;
            r_q   <= '0;
            cnt_q <= '0;
            if (div_in == '0) begin
                state_q     <= DONE;
                quotient_q  <= '1;
                remainder_q <= '0;
                div_zero_q  <= 1'b1;
                vld_out_q   <= 1'b1;
            end
`ifdef NOC_DIV_POW2_BYPASS_EN
            else if (is_pow2(32'(div_in))) begin
                state_q     <= DONE;
                quotient_q  <= data_in >> log2_onehot(32'(div_in));
                remainder_q <= data_in[DIV_WIDTH-1:0] & (div_in - DIV_WIDTH'(1));
                div_zero_q  <= 1'b0;
                vld_out_q   <= 1'b1;
            end
`endif
            else begin
                state_q   <= CALC;
                vld_out_q <= 1'b0;
            end
        end else begin
            case (state_q)
                CALC: begin
                    dvd_q <= {dvd_q[ADDR_WIDTH-2:0], q_bit_d};
                    r_q   <= r_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        quotient_q  <= {dvd_q[ADDR_WIDTH-2:0], q_bit_d};
                        remainder_q <= r_d;
                        div_zero_q  <= 1'b0;
                        vld_out_q   <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (rdy_out) begin
                        state_q   <= IDLE;
                        vld_out_q <= 1'b0;
                    end
                end
                IDLE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_serial_divider.sv
// Directed self-checking bench for noc_serial_divider (default 20/4 widths).
module tb_noc_serial_divider;

    localparam int AW = 20;
    localparam int DW = 4;

    logic          clk;
    logic          rst_n;
    logic          vld_in;
    logic          rdy_in;
    logic [AW-1:0] data_in;
    logic [DW-1:0] div_in;
    logic [AW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_zero;
    logic          vld_out;
    logic          rdy_out;

    int pass_cnt  = 0;
    int check_cnt = 0;

    noc_serial_divider #(
        .ADDR_WIDTH (AW),
        .DIV_WIDTH  (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_in    (vld_in),
        .rdy_in    (rdy_in),
        .data_in   (data_in),
        .div_in    (div_in),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .vld_out   (vld_out),
        .rdy_out   (rdy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents operands, waits (bounded) for rdy_in, and returns 1ns after the accepting edge.
    task automatic start_op(input logic [AW-1:0] d, input logic [DW-1:0] v);
        int n;
        n = 0;
        while (!rdy_in && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check_cnt++;
        if (!rdy_in) $display("FAIL accept_wait: rdy_in=%0b required 1", rdy_in);
        else pass_cnt++;
        data_in = d;
        div_in  = v;
        vld_in  = 1'b1;
        @(posedge clk); #1;
        vld_in  = 1'b0;
    endtask

    // Counts edges after the accepting edge until vld_out; 0 means the result
    // was registered on the accepting edge itself (single-edge latency).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!vld_out && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        $display("op %0d / %0d -> q=%0d r=%0d dz=%0b after %0d edges",
                 data_in, div_in, quotient, remainder, div_zero, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld_in = 1'b0; rdy_out = 1'b1; data_in = '0; div_in = '0;
        #1;
        check_cnt++; if (vld_out !== 1'b0)  $display("FAIL reset_vld_out: got %0b required 0", vld_out); else pass_cnt++;
        check_cnt++; if (quotient !== '0)   $display("FAIL reset_quotient: got %0h required 0", quotient); else pass_cnt++;
        check_cnt++; if (remainder !== '0)  $display("FAIL reset_remainder: got %0h required 0", remainder); else pass_cnt++;
        check_cnt++; if (div_zero !== 1'b0) $display("FAIL reset_div_zero: got %0b required 0", div_zero); else pass_cnt++;
        check_cnt++; if (rdy_in !== 1'b1)   $display("FAIL reset_rdy_in: got %0b required 1", rdy_in); else pass_cnt++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        int lat;
        start_op(20'd1000, 4'd3);
        wait_result(lat);
        check_cnt++; if (lat !== 20)         $display("FAIL nominal_latency: got %0d required 20", lat); else pass_cnt++;
        check_cnt++; if (quotient !== 20'd333) $display("FAIL nominal_q: got %0d required 333", quotient); else pass_cnt++;
        check_cnt++; if (remainder !== 4'd1) $display("FAIL nominal_r: got %0d required 1", remainder); else pass_cnt++;
        check_cnt++; if (div_zero !== 1'b0)  $display("FAIL nominal_dz: got %0b required 0", div_zero); else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++; if (vld_out !== 1'b0)   $display("FAIL nominal_drain_vld: got %0b required 0", vld_out); else pass_cnt++;
        check_cnt++; if (quotient !== 20'd333) $display("FAIL nominal_hold_q: got %0d required 333", quotient); else pass_cnt++;
        check_cnt++; if (rdy_in !== 1'b1)    $display("FAIL nominal_idle_rdy: got %0b required 1", rdy_in); else pass_cnt++;
    endtask

    task automatic test_max_operands();
        int lat;
        start_op(20'hFFFFF, 4'd15);
        wait_result(lat);
        check_cnt++; if (quotient !== 20'd69905) $display("FAIL max_q: got %0d required 69905", quotient); else pass_cnt++;
        check_cnt++; if (remainder !== 4'd0)   $display("FAIL max_r: got %0d required 0", remainder); else pass_cnt++;
        check_cnt++; if (lat !== 20)           $display("FAIL max_latency: got %0d required 20", lat); else pass_cnt++;
        @(posedge clk); #1;
        start_op(20'd0, 4'd7);
        wait_result(lat);
        check_cnt++; if (quotient !== 20'd0)   $display("FAIL zero_dividend_q: got %0d required 0", quotient); else pass_cnt++;
        check_cnt++; if (remainder !== 4'd0)   $display("FAIL zero_dividend_r: got %0d required 0", remainder); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int lat;
        start_op(20'h12345, 4'd0);
        wait_result(lat);
        check_cnt++; if (lat !== 0)            $display("FAIL divzero_latency: got %0d extra edges required 0", lat); else pass_cnt++;
        check_cnt++; if (quotient !== 20'hFFFFF) $display("FAIL divzero_q: got %0h required fffff", quotient); else pass_cnt++;
        check_cnt++; if (remainder !== 4'd0)   $display("FAIL divzero_r: got %0d required 0", remainder); else pass_cnt++;
        check_cnt++; if (div_zero !== 1'b1)    $display("FAIL divzero_flag: got %0b required 1", div_zero); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        rdy_out = 1'b0;
        start_op(20'd100, 4'd6);
        wait_result(lat);
        check_cnt++; if (div_zero !== 1'b0) $display("FAIL bp_dz_cleared: got %0b required 0", div_zero); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_cnt++;
            if ({vld_out, quotient, remainder, rdy_in} !== {1'b1, 20'd16, 4'd4, 1'b0})
                $display("FAIL bp_stall_%0d: got vld=%0b q=%0d r=%0d rdy_in=%0b required vld=1 q=16 r=4 rdy_in=0",
                         i, vld_out, quotient, remainder, rdy_in);
            else pass_cnt++;
        end
        data_in = 20'd50; div_in = 4'd7; vld_in = 1'b1; rdy_out = 1'b1;
        #1;
        check_cnt++; if (rdy_in !== 1'b1) $display("FAIL b2b_rdy_in: got %0b required 1", rdy_in); else pass_cnt++;
        @(posedge clk); #1;
        vld_in = 1'b0;
        check_cnt++; if (vld_out !== 1'b0 || rdy_in !== 1'b0)
            $display("FAIL b2b_accepted: got vld=%0b rdy_in=%0b required 0 0", vld_out, rdy_in); else pass_cnt++;
        wait_result(lat);
        check_cnt++; if (lat !== 20)         $display("FAIL b2b_latency: got %0d required 20", lat); else pass_cnt++;
        check_cnt++; if (quotient !== 20'd7) $display("FAIL b2b_q: got %0d required 7", quotient); else pass_cnt++;
        check_cnt++; if (remainder !== 4'd1) $display("FAIL b2b_r: got %0d required 1", remainder); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_pow2();
        int lat;
        int exp_lat;
`ifdef NOC_DIV_POW2_BYPASS_EN
        exp_lat = 0;
`else
        exp_lat = 20;
`endif
        start_op(20'h12345, 4'd8);
        wait_result(lat);
        check_cnt++; if (lat !== exp_lat)       $display("FAIL pow2_latency: got %0d required %0d", lat, exp_lat); else pass_cnt++;
        check_cnt++; if (quotient !== 20'h2468) $display("FAIL pow2_q: got %0h required 2468", quotient); else pass_cnt++;
        check_cnt++; if (remainder !== 4'd5)    $display("FAIL pow2_r: got %0d required 5", remainder); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        start_op(20'd1000, 4'd3);
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({vld_out, quotient, remainder, div_zero} !== '0)
            $display("FAIL midreset_outputs: got vld=%0b q=%0d r=%0d dz=%0b required all 0",
                     vld_out, quotient, remainder, div_zero);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_cnt++; if (rdy_in !== 1'b1) $display("FAIL midreset_rdy_in: got %0b required 1", rdy_in); else pass_cnt++;
        @(posedge clk); #1;
        start_op(20'd1000, 4'd3);
        wait_result(lat);
        check_cnt++; if (quotient !== 20'd333 || remainder !== 4'd1)
            $display("FAIL midreset_rerun: got q=%0d r=%0d required q=333 r=1", quotient, remainder);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_max_operands();
        test_div_zero();
        test_back_to_back();
        test_pow2();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/noc_serial_divider.md
Name: noc_serial_divider

Overview:
- Parametrised multi-cycle unsigned divider for the NoC master unit.
- Successor to the fixed divide-by-three FSM: the divisor is now a runtime operand (div_in), and the block adds a full valid/ready handshake on both sides.
- Used for address/stride decomposition (node index, bank, offset) where the divisor is a small runtime constant.
- Restoring radix-2 division, one quotient bit per clock.

Parameters:
- ADDR_WIDTH, 20, dividend and quotient width; must satisfy ADDR_WIDTH >= DIV_WIDTH >= 2.
- DIV_WIDTH, 4, divisor and remainder width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- vld_in  input  1  operand valid.
- rdy_in  output  1  block can accept operands.
- data_in  input  ADDR_WIDTH  unsigned dividend.
- div_in  input  DIV_WIDTH  unsigned divisor.
- quotient  output  ADDR_WIDTH  registered quotient.
- remainder  output  DIV_WIDTH  registered remainder.
- div_zero  output  1  result came from a zero divisor.
- vld_out  output  1  result valid.
- rdy_out  input  1  downstream accepts result.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, quotient=0, remainder=0, div_zero=0, vld_out=0. Internal counter, dividend shift register, divisor register and partial remainder also reset to 0.
- States: IDLE, CALC, DONE.
- rdy_in = (state==IDLE) | (state==DONE & rdy_out).
- Accept: operands are captured on an edge where vld_in & rdy_in. Capture loads the dividend shift register, divisor register, partial remainder r=0 and cnt=0.
- Accept, div_in != 0: next state CALC.
- Accept, div_in == 0: next state DONE. quotient = all ones, remainder = 0, div_zero = 1. No CALC cycles.
- CALC, each edge:
  - r' = {r[DIV_WIDTH-1:0], dividend MSB}, r is DIV_WIDTH+1 bits.
  - If r' >= divisor: r = r' - divisor, and 1 is shifted into the quotient LSB.
  - Otherwise: r = r', and 0 is shifted into the quotient LSB.
  - Dividend shifts left by 1; cnt increments.
- CALC exit: on the edge where cnt == ADDR_WIDTH-1, the final quotient and remainder (r[DIV_WIDTH-1:0]) are written, div_zero=0, vld_out=1, state goes to DONE.
- Latency: vld_out is high exactly ADDR_WIDTH edges after the accepting edge for a nonzero divisor, and 1 edge after for a zero divisor.
- DONE: quotient, remainder, div_zero and vld_out are held stable while rdy_out=0, i.e. under backpressure.
- DONE with rdy_out=1:
  - Without a new vld_in: next state IDLE, vld_out=0.
  - With vld_in: the new operands are accepted on the same edge, giving back-to-back operation; vld_out drops for the CALC cycles that follow.
- Steady-state throughput: one result per ADDR_WIDTH+1 cycles.
- No cancel or abort. vld_in and operand values seen during CALC are ignored (rdy_in=0).
- Output registers keep the last result after the transfer until the next write.
- Reset asserted mid-operation: the block returns to IDLE immediately, all outputs go to reset values, and the in-flight operation is discarded.

Optional Feature:
- Macro: NOC_DIV_POW2_BYPASS_EN.
- Defined: an accepted nonzero divisor with exactly one bit set skips CALC. Next state is DONE with quotient = data_in >> log2(div_in), remainder = data_in & (div_in-1), div_zero=0. Latency is 1 edge.
- Undefined: every nonzero divisor takes the full ADDR_WIDTH-cycle CALC path. Results are identical; only timing differs.

Decomposition:
- Package noc_div_pkg:
  - state enum (IDLE/CALC/DONE);
  - counter width constant CNT_W = $clog2(ADDR_WIDTH)+1;
  - a power-of-two detect function;
  - a log2 one-hot-to-index function.
- One natural sub-module, noc_div_step: the combinational restoring step. Inputs r, dividend bit and divisor; outputs next r and quotient bit. Instantiated once inside the FSM datapath.

Test Plan:
- Nominal: data_in=1000, div_in=3, rdy_out=1 -> vld_out rises 20 edges after accept; quotient=333, remainder=1, div_zero=0.
- Max operands: data_in=0xFFFFF, div_in=15 -> quotient=69905, remainder=0. Also data_in=0, div_in=7 -> quotient=0, remainder=0.
- Divide by zero: data_in=0x12345, div_in=0 -> vld_out one edge later; quotient=0xFFFFF, remainder=0, div_zero=1.
- Backpressure and back-to-back:
  - Setup: 100/6, rdy_out held 0 for 5 cycles, then rdy_out=1 with vld_in=1 carrying 50/7.
  - Required: outputs stable q=16 r=4 during stall; second operands accepted on the release edge; q=7 r=1 follows 20 edges later.
- Pow2 path: data_in=0x12345, div_in=8 -> q=0x2468, r=5. With NOC_DIV_POW2_BYPASS_EN the latency is 1 edge; without the macro it is 20 edges.
- Reset mid-CALC: assert rst_n=0 at cnt=10 -> vld_out, quotient, remainder and div_zero are 0 and rdy_in=1 after release. A subsequent 1000/3 still yields 333 r1.
